// File: rtl/seqdet_prog_ctrl_if.sv
// Control and serial-stream bundle for seqdet_prog_ctrl.
// SEQDET_TIMEOUT_EN adds the timeout configuration and pulse signals.
interface seqdet_prog_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
`ifdef SEQDET_TIMEOUT_EN
  , parameter int TMO_W = 16
`endif
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             i_cfg_we;
  logic [PAT_W-1:0] i_cfg_pattern;
  logic [LEN_W-1:0] i_cfg_len;
  logic             i_cfg_overlap;
  logic [CNT_W-1:0] i_cfg_target;
  logic             i_start;
  logic             i_stop;
  logic             i_valid;
  logic             i_data;
  logic             o_busy;
  logic             o_det;
  logic [CNT_W-1:0] o_match_cnt;
  logic             o_done;
  logic             o_cfg_err;
`ifdef SEQDET_TIMEOUT_EN
  logic [TMO_W-1:0] i_cfg_timeout;
  logic             o_timeout;
`endif

  modport master (
    output i_cfg_we, i_cfg_pattern, i_cfg_len, i_cfg_overlap, i_cfg_target,
    output i_start, i_stop, i_valid, i_data,
`ifdef SEQDET_TIMEOUT_EN
    output i_cfg_timeout,
    input  o_timeout,
`endif
    input  o_busy, o_det, o_match_cnt, o_done, o_cfg_err
  );

  modport slave (
    input  i_cfg_we, i_cfg_pattern, i_cfg_len, i_cfg_overlap, i_cfg_target,
    input  i_start, i_stop, i_valid, i_data,
`ifdef SEQDET_TIMEOUT_EN
    input  i_cfg_timeout,
    output o_timeout,
`endif
    output o_busy, o_det, o_match_cnt, o_done, o_cfg_err
  );
endinterface

// File: rtl/seqdet_prog_ctrl.sv
// Run controller for a programmable serial pattern detector with match counting.
// Optional run timeout is enabled by defining SEQDET_TIMEOUT_EN.
module seqdet_prog_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
`ifdef SEQDET_TIMEOUT_EN
  , parameter int TMO_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  seqdet_prog_ctrl_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic [CNT_W-1:0] target;
  // Only PAT_W-1 history bits need storing: the newest bit comes straight from i_data.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic             det, done, cfg_err, busy;
  logic [CNT_W-1:0] match_cnt;

  logic [PAT_W-1:0] hist_n, mask;
  logic [LEN_W-1:0] fill_n;
  logic [CNT_W-1:0] cnt_n;
  logic             match, tgt_hit, len_ok;

`ifdef SEQDET_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_val, tmo_cnt, tmo_cnt_n;
  logic             tmo_hit, timeout;
`endif

  // NOTE: every always_comb output is assigned unconditionally, so no latch is inferred.
  always_comb begin
    hist_n  = {hist, bus.i_data};
    fill_n  = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    mask    = ~({PAT_W{1'b1}} << len);
    match   = (state == RUN) && bus.i_valid &&
              ((hist_n & mask) == (pattern & mask)) && (fill_n >= len);
    cnt_n   = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    tgt_hit = match && (target != '0) && (cnt_n == target);
    len_ok  = (len != '0) && (len <= LEN_W'(PAT_W));
`ifdef SEQDET_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt + TMO_W'(1);
    tmo_hit   = (tmo_val != '0) && (tmo_cnt_n == tmo_val) && !match;
`endif
  end

  // NOTE: state and outputs use nonblocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pattern   <= PAT_W'(4'b1101);
      len       <= LEN_W'(4);
      overlap   <= 1'b1;
      target    <= '0;
      hist      <= '0;
      fill      <= '0;
      det       <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      match_cnt <= '0;
`ifdef SEQDET_TIMEOUT_EN
      tmo_val   <= '0;
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      det  <= match;
      done <= 1'b0;
`ifdef SEQDET_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.i_cfg_we) begin
            pattern <= bus.i_cfg_pattern;
            len     <= bus.i_cfg_len;
            overlap <= bus.i_cfg_overlap;
            target  <= bus.i_cfg_target;
            cfg_err <= 1'b0;
`ifdef SEQDET_TIMEOUT_EN
            tmo_val <= bus.i_cfg_timeout;
`endif
          end
          if (bus.i_start) begin
            if (len_ok) begin
              state     <= RUN;
              busy      <= 1'b1;
              hist      <= '0;
              fill      <= '0;
              match_cnt <= '0;
`ifdef SEQDET_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.i_valid) begin
            hist <= hist_n[PAT_W-2:0];
            fill <= (match && !overlap) ? '0 : fill_n;
          end
          if (match) match_cnt <= cnt_n;
`ifdef SEQDET_TIMEOUT_EN
          tmo_cnt <= match ? '0 : tmo_cnt_n;
`endif
          // Stop wins over target: the match is still counted but no done pulse.
          if (bus.i_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tgt_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef SEQDET_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = busy;
  assign bus.o_det       = det;
  assign bus.o_match_cnt = match_cnt;
  assign bus.o_done      = done;
  assign bus.o_cfg_err   = cfg_err;
`ifdef SEQDET_TIMEOUT_EN
  assign bus.o_timeout   = timeout;
`endif
endmodule

// File: tb/tb_seqdet_prog_ctrl.sv
// Directed bench for seqdet_prog_ctrl: a bit-queue reference model fills a
// scoreboard per driven bit; entries are popped and compared after the edge.
module tb_seqdet_prog_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seqdet_prog_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  seqdet_prog_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             det;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [PAT_W-1:0] m_pat;
  int               m_len, m_tgt, m_cnt;
  bit               m_ov, m_run, m_err;
  bit               rx_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pat = PAT_W'(4'b1101);
    m_len = 4;
    m_ov  = 1'b1;
    m_tgt = 0;
    m_cnt = 0;
    m_run = 1'b0;
    m_err = 1'b0;
    rx_q.delete();
  endtask

  task automatic send_bit(bit v, bit d, bit stop = 1'b0);
    exp_t e;
    bit   hit;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_stop  = stop;
    e.det  = 1'b0;
    e.done = 1'b0;
    if (m_run && v) begin
      rx_q.push_back(d);
      hit = (rx_q.size() >= m_len);
      for (int i = 0; i < m_len && hit; i++)
        if (rx_q[rx_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      if (hit) begin
        e.det = 1'b1;
        if (m_cnt != CNT_MAX) m_cnt++;
        if (!m_ov) rx_q.delete();
        if (!stop && m_tgt != 0 && m_cnt == m_tgt) begin
          e.done = 1'b1;
          m_run  = 1'b0;
        end
      end
    end
    if (stop) m_run = 1'b0;
    e.busy = m_run;
    e.cnt  = CNT_W'(m_cnt);
    sb_q.push_back(e);
    tick();
    bus.i_valid = 1'b0;
    bus.i_stop  = 1'b0;
    e = sb_q.pop_front();
    check("det",  32'(bus.o_det),       32'(e.det));
    check("done", 32'(bus.o_done),      32'(e.done));
    check("busy", 32'(bus.o_busy),      32'(e.busy));
    check("cnt",  32'(bus.o_match_cnt), 32'(e.cnt));
  endtask

  task automatic send_bits(logic [15:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) send_bit(1'b1, bits[i]);
  endtask

  task automatic do_cfg(logic [PAT_W-1:0] pat, int len, bit ov, int tgt);
    bus.i_cfg_we      = 1'b1;
    bus.i_cfg_pattern = pat;
    bus.i_cfg_len     = LEN_W'(len);
    bus.i_cfg_overlap = ov;
    bus.i_cfg_target  = CNT_W'(tgt);
    tick();
    bus.i_cfg_we = 1'b0;
    m_pat = pat;
    m_len = len;
    m_ov  = ov;
    m_tgt = tgt;
    m_err = 1'b0;
    check("cfg_err_clr", 32'(bus.o_cfg_err), 32'(m_err));
  endtask

  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    if (m_len >= 1 && m_len <= PAT_W) begin
      m_run = 1'b1;
      m_cnt = 0;
      rx_q.delete();
    end else begin
      m_err = 1'b1;
    end
    check("start_busy", 32'(bus.o_busy),      32'(m_run));
    check("start_err",  32'(bus.o_cfg_err),   32'(m_err));
    check("start_cnt",  32'(bus.o_match_cnt), 32'(m_cnt));
  endtask

  task automatic do_stop();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    m_run = 1'b0;
    check("stop_busy", 32'(bus.o_busy),      32'(0));
    check("stop_cnt",  32'(bus.o_match_cnt), 32'(m_cnt));
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy"}, 32'(bus.o_busy),      32'(0));
    check({tag, "_det"},  32'(bus.o_det),       32'(0));
    check({tag, "_cnt"},  32'(bus.o_match_cnt), 32'(0));
    check({tag, "_done"}, 32'(bus.o_done),      32'(0));
    check({tag, "_err"},  32'(bus.o_cfg_err),   32'(0));
  endtask

  initial begin
    bus.i_cfg_we      = 1'b0;
    bus.i_cfg_pattern = '0;
    bus.i_cfg_len     = '0;
    bus.i_cfg_overlap = 1'b0;
    bus.i_cfg_target  = '0;
    bus.i_start       = 1'b0;
    bus.i_stop        = 1'b0;
    bus.i_valid       = 1'b0;
    bus.i_data        = 1'b0;
`ifdef SEQDET_TIMEOUT_EN
    bus.i_cfg_timeout = '0;
`endif
    model_reset();
    reset = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Reset configuration, overlapping: matches after bits 4 and 7
    do_start();
    send_bits(16'b1101101, 7);
    check("t1_cnt", 32'(bus.o_match_cnt), 32'(2));
    do_stop();

    // Non-overlap: only the first match
    do_cfg(8'b1101, 4, 1'b0, 0);
    do_start();
    send_bits(16'b1101101, 7);
    check("t2_cnt", 32'(bus.o_match_cnt), 32'(1));
    do_stop();

    // Target 3: done after the third match, fourth pattern discarded
    do_cfg(8'b1101, 4, 1'b1, 3);
    do_start();
    send_bits(16'b1101_1101_1101_1101, 16);
    check("t3_cnt",  32'(bus.o_match_cnt), 32'(3));
    check("t3_busy", 32'(bus.o_busy),      32'(0));

    // Illegal length sets the sticky error; next config write clears it
    do_cfg(8'b1101, 0, 1'b1, 0);
    do_start();
    check("t4_err", 32'(bus.o_cfg_err), 32'(1));
    tick();
    check("t4_err_hold", 32'(bus.o_cfg_err), 32'(1));
    do_cfg(8'b101, 3, 1'b1, 0);

    // Valid gaps between pattern bits, then asynchronous reset mid-run
    do_start();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check("t5_det", 32'(bus.o_det), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Config came back to reset values: default 1101 pattern detected
    do_start();
    send_bits(16'b01101, 5);
    check("t6_cnt", 32'(bus.o_match_cnt), 32'(1));
    do_stop();

    // Full-width pattern, non-overlap
    do_cfg(8'hA5, 8, 1'b0, 0);
    do_start();
    send_bits(16'h5A5, 12);
    check("t7_cnt", 32'(bus.o_match_cnt), 32'(1));
    do_stop();

    // Stop coincident with the target-reaching match: counted, no done
    do_cfg(8'b1101, 4, 1'b1, 1);
    do_start();
    send_bits(16'b110, 3);
    send_bit(1'b1, 1'b1, 1'b1);
    tick();
    check("t8_no_done", 32'(bus.o_done), 32'(0));
    check("t8_cnt",     32'(bus.o_match_cnt), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
